// File: rtl/uart_wb_bridge_if.sv
// Byte-stream (UART RX/TX engine) and Wishbone classic signals of the debug bridge.
// The bridge takes the master modport; the UART engines and bus slave take the slave modport.
interface uart_wb_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [7:0]            i_RX_DATA;
  logic                  i_RX_VALID;
  logic [7:0]            o_TX_DATA;
  logic                  o_TX_VALID;
  logic                  i_TX_READY;
  logic [ADDR_WIDTH-1:0] o_ADDR;
  logic [DATA_WIDTH-1:0] o_DATA;
  logic [DATA_WIDTH-1:0] i_DATA;
  logic                  o_WE;
  logic [3:0]            o_SEL;
  logic                  o_STB;
  logic                  o_CYC;
  logic                  i_ACK;
  logic                  o_OVERRUN;

  modport master (
    input  i_RX_DATA, i_RX_VALID, i_TX_READY, i_DATA, i_ACK,
    output o_TX_DATA, o_TX_VALID, o_ADDR, o_DATA, o_WE, o_SEL, o_STB, o_CYC, o_OVERRUN
  );

  modport slave (
    output i_RX_DATA, i_RX_VALID, i_TX_READY, i_DATA, i_ACK,
    input  o_TX_DATA, o_TX_VALID, o_ADDR, o_DATA, o_WE, o_SEL, o_STB, o_CYC, o_OVERRUN
  );
endinterface

// File: rtl/uart_wb_bridge.sv
// Serial 'W'/'R' frame decoder that issues one 32-bit Wishbone classic cycle per frame.
// STB rises 1 cycle after the last frame byte; RX has no backpressure (dropped bytes set overrun), TX waits on ready.
module uart_wb_bridge #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int BUS_TIMEOUT  = 1024,
  parameter int IDLE_TIMEOUT = 1250000
) (
  input  logic                 i_CLK,
  input  logic                 i_RST,
  uart_wb_bridge_if.master     bus_io
);

  localparam logic [7:0] OP_W    = 8'h57;
  localparam logic [7:0] OP_R    = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_ERR = 8'h15;
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam int BW = $clog2(BUS_TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);
  localparam logic [BW-1:0] BUS_LAST  = BW'(BUS_TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WDATA, S_BUS, S_RESP} state_t;

  state_t        state_q, state_d;
  logic          is_wr_q, is_wr_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [1:0]    rsp_last_q, rsp_last_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdat_q, wdat_d;
  logic [31:0]   rsp_q, rsp_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [BW-1:0] bus_q, bus_d;
  logic          ovr_q, ovr_d;
  logic          idle_expired;

  assign idle_expired = (idle_q == IDLE_LAST);

  always_comb begin
    state_d    = state_q;
    is_wr_d    = is_wr_q;
    cnt_d      = cnt_q;
    rsp_last_d = rsp_last_q;
    addr_d     = addr_q;
    wdat_d     = wdat_q;
    rsp_d      = rsp_q;
    idle_d     = idle_q;
    bus_d      = bus_q;
    ovr_d      = ovr_q;

    if (bus_io.i_RX_VALID && (state_q == S_BUS || state_q == S_RESP)) begin
      ovr_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (bus_io.i_RX_VALID) begin
          cnt_d  = 2'd0;
          idle_d = '0;
          if (bus_io.i_RX_DATA == OP_W || bus_io.i_RX_DATA == OP_R) begin
            is_wr_d = (bus_io.i_RX_DATA == OP_W);
            state_d = S_ADDR;
          end else begin
            rsp_d      = {24'h0, RSP_ERR};
            rsp_last_d = 2'd0;
            state_d    = S_RESP;
          end
        end
      end

      // Timeout is checked first so a byte arriving on the expiry cycle is discarded.
      S_ADDR, S_WDATA: begin
        if (idle_expired) begin
          state_d = S_IDLE;
        end else if (bus_io.i_RX_VALID) begin
          idle_d = '0;
          cnt_d  = cnt_q + 2'd1;
          if (state_q == S_ADDR) begin
            addr_d = {bus_io.i_RX_DATA, addr_q[31:8]};
          end else begin
            wdat_d = {bus_io.i_RX_DATA, wdat_q[31:8]};
          end
          if (cnt_q == 2'd3) begin
            bus_d   = '0;
            state_d = (state_q == S_ADDR && is_wr_q) ? S_WDATA : S_BUS;
          end
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end

      // ACK is tested before the timeout so a late ACK still completes normally.
      S_BUS: begin
        if (bus_io.i_ACK) begin
          rsp_d      = is_wr_q ? {24'h0, RSP_ACK} : 32'(bus_io.i_DATA);
          rsp_last_d = is_wr_q ? 2'd0 : 2'd3;
          cnt_d      = 2'd0;
          state_d    = S_RESP;
        end else if (bus_q == BUS_LAST) begin
          rsp_d      = {24'h0, RSP_ERR};
          rsp_last_d = 2'd0;
          cnt_d      = 2'd0;
          state_d    = S_RESP;
        end else begin
          bus_d = bus_q + 1'b1;
        end
      end

      S_RESP: begin
        if (bus_io.i_TX_READY) begin
          if (cnt_q == rsp_last_q) begin
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 2'd1;
            rsp_d = {8'h00, rsp_q[31:8]};
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q    <= S_IDLE;
      is_wr_q    <= 1'b0;
      cnt_q      <= 2'd0;
      rsp_last_q <= 2'd0;
      addr_q     <= '0;
      wdat_q     <= '0;
      rsp_q      <= '0;
      idle_q     <= '0;
      bus_q      <= '0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_wr_q    <= is_wr_d;
      cnt_q      <= cnt_d;
      rsp_last_q <= rsp_last_d;
      addr_q     <= addr_d;
      wdat_q     <= wdat_d;
      rsp_q      <= rsp_d;
      idle_q     <= idle_d;
      bus_q      <= bus_d;
      ovr_q      <= ovr_d;
    end
  end

  assign bus_io.o_CYC      = (state_q == S_BUS);
  assign bus_io.o_STB      = (state_q == S_BUS);
  assign bus_io.o_WE       = (state_q == S_BUS) && is_wr_q;
  assign bus_io.o_SEL      = 4'b1111;
  assign bus_io.o_ADDR     = addr_q[ADDR_WIDTH-1:0];
  assign bus_io.o_DATA     = DATA_WIDTH'(wdat_q);
  assign bus_io.o_TX_VALID = (state_q == S_RESP);
  assign bus_io.o_TX_DATA  = rsp_q[7:0];
  assign bus_io.o_OVERRUN  = ovr_q;

endmodule

// File: tb/tb_uart_wb_bridge.sv
// Scoreboard bench for uart_wb_bridge: expected TX bytes are queued as frames are sent and popped as they appear.
module tb_uart_wb_bridge;
  localparam int BUS_TO  = 16;
  localparam int IDLE_TO = 100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_wb_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bif ();

  uart_wb_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .BUS_TIMEOUT(BUS_TO), .IDLE_TIMEOUT(IDLE_TO)
  ) dut (
    .i_CLK(clk), .i_RST(rst), .bus_io(bif)
  );

  int chk_cnt = 0;
  int pass_cnt = 0;
  logic [7:0] exp_q[$];

  // Bus slave model, sampled/driven on the falling edge.
  bit          ack_en = 1'b1;
  int          ack_delay = 0;
  logic [31:0] rd_data = 32'h0;
  int          stb_len = 0;
  int          bus_cycles = 0;
  int          unstable_bus = 0;
  logic        prev_stb = 1'b0;
  logic [31:0] last_addr = 32'h0;
  logic [31:0] last_dat = 32'h0;
  logic        last_we = 1'b0;
  logic [3:0]  last_sel = 4'h0;

  always @(negedge clk) begin
    if (bif.o_STB) begin
      if (!prev_stb) begin
        stb_len = 0;
        bus_cycles++;
      end else if (bif.o_ADDR !== last_addr || bif.o_DATA !== last_dat || bif.o_WE !== last_we) begin
        unstable_bus++;
      end
      stb_len++;
      last_addr = bif.o_ADDR;
      last_dat  = bif.o_DATA;
      last_we   = bif.o_WE;
      last_sel  = bif.o_SEL;
      bif.i_ACK  = ack_en && (stb_len > ack_delay);
      bif.i_DATA = bif.i_ACK ? rd_data : 32'h0;
    end else begin
      bif.i_ACK  = 1'b0;
      bif.i_DATA = 32'h0;
    end
    prev_stb = bif.o_STB;
  end

  int tx_hs = 0;
  always @(posedge clk) begin
    if (!rst && bif.o_TX_VALID && bif.i_TX_READY) tx_hs <= tx_hs + 1;
  end

  int         tx_unstable = 0;
  logic       held;
  logic [7:0] held_dat;

  task automatic send_byte(input logic [7:0] b);
    bif.i_RX_DATA  = b;
    bif.i_RX_VALID = 1'b1;
    @(negedge clk);
    bif.i_RX_VALID = 1'b0;
  endtask

  task automatic send_read(input logic [31:0] a);
    send_byte(8'h52);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
  endtask

  task automatic send_write(input logic [31:0] a, input logic [31:0] d);
    send_byte(8'h57);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
  endtask

  task automatic wait_tx(input bit toggle, input int limit, output logic [7:0] b, output bit ok);
    ok = 1'b0;
    b = 8'h0;
    held = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      bif.i_TX_READY = toggle ? ~bif.i_TX_READY : 1'b1;
      if (bif.o_TX_VALID) begin
        if (held && bif.o_TX_DATA !== held_dat) tx_unstable++;
        if (bif.i_TX_READY) begin
          b = bif.o_TX_DATA;
          ok = 1'b1;
        end else begin
          held = 1'b1;
          held_dat = bif.o_TX_DATA;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic drain(input string nm, input int n, input bit toggle);
    logic [7:0] b, e;
    bit ok;
    for (int k = 0; k < n; k++) begin
      wait_tx(toggle, 64, b, ok);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      chk_cnt++;
      if (!ok) $display("FAIL %s tx%0d: no TX byte within 64 cycles, required %02h", nm, k, e);
      else if (b !== e) $display("FAIL %s tx%0d: got %02h required %02h", nm, k, b, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_cnt++; if ({bif.o_TX_VALID, bif.o_STB, bif.o_CYC, bif.o_WE, bif.o_OVERRUN} !== 5'b0)
      $display("FAIL reset_ctrl: got %b required 00000", {bif.o_TX_VALID, bif.o_STB, bif.o_CYC, bif.o_WE, bif.o_OVERRUN});
    else pass_cnt++;
    chk_cnt++; if (bif.o_SEL !== 4'hF) $display("FAIL reset_sel: got %h required f", bif.o_SEL); else pass_cnt++;
    chk_cnt++; if ({bif.o_ADDR, bif.o_DATA, bif.o_TX_DATA} !== 72'h0)
      $display("FAIL reset_data: got %h/%h/%h required 0", bif.o_ADDR, bif.o_DATA, bif.o_TX_DATA);
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write();
    int base = bus_cycles;
    ack_en = 1'b1; ack_delay = 3;
    exp_q.push_back(8'h06);
    send_write(32'h8000_0010, 32'hDEAD_BEEF);
    chk_cnt++; if ({bif.o_STB, bif.o_CYC, bif.o_WE} !== 3'b111)
      $display("FAIL write_latency: stb/cyc/we got %b required 111", {bif.o_STB, bif.o_CYC, bif.o_WE});
    else pass_cnt++;
    drain("write", 1, 1'b0);
    chk_cnt++; if (last_addr !== 32'h8000_0010 || last_dat !== 32'hDEAD_BEEF || last_sel !== 4'hF)
      $display("FAIL write_bus: got %h/%h/%h required 80000010/deadbeef/f", last_addr, last_dat, last_sel);
    else pass_cnt++;
    chk_cnt++; if (bus_cycles - base !== 1 || stb_len !== 4 || unstable_bus !== 0)
      $display("FAIL write_cycle: cycles %0d len %0d unstable %0d required 1/4/0", bus_cycles - base, stb_len, unstable_bus);
    else pass_cnt++;
  endtask

  task automatic test_read();
    ack_en = 1'b1; ack_delay = 1; rd_data = 32'h1234_5678;
    tx_unstable = 0;
    bif.i_TX_READY = 1'b0;
    exp_q.push_back(8'h78); exp_q.push_back(8'h56); exp_q.push_back(8'h34); exp_q.push_back(8'h12);
    send_read(32'h8000_0004);
    chk_cnt++; if ({bif.o_STB, bif.o_WE} !== 2'b10 || bif.o_ADDR !== 32'h8000_0004)
      $display("FAIL read_bus: stb/we %b addr %h required 10/80000004", {bif.o_STB, bif.o_WE}, bif.o_ADDR);
    else pass_cnt++;
    drain("read", 4, 1'b1);
    chk_cnt++; if (tx_unstable !== 0) $display("FAIL read_tx_stable: changes %0d required 0", tx_unstable); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (bif.o_TX_VALID !== 1'b0) $display("FAIL read_tx_end: valid %b required 0", bif.o_TX_VALID); else pass_cnt++;
  endtask

  task automatic test_bad_opcode();
    int base = bus_cycles;
    ack_delay = 0; rd_data = 32'h0BAD_F00D;
    exp_q.push_back(8'h15);
    send_byte(8'h41);
    drain("badop", 1, 1'b0);
    chk_cnt++; if (bus_cycles !== base) $display("FAIL badop_nobus: cycles %0d required %0d", bus_cycles, base); else pass_cnt++;
    exp_q.push_back(8'h0D); exp_q.push_back(8'hF0); exp_q.push_back(8'hAD); exp_q.push_back(8'h0B);
    send_read(32'h0000_0100);
    drain("badop_next", 4, 1'b0);
    chk_cnt++; if (last_addr !== 32'h0000_0100) $display("FAIL badop_next_addr: got %h required 00000100", last_addr); else pass_cnt++;
  endtask

  task automatic test_idle_timeout();
    int base_bus = bus_cycles;
    int base_tx = tx_hs;
    send_byte(8'h57); send_byte(8'h01); send_byte(8'h02);
    repeat (IDLE_TO + 10) @(negedge clk);
    chk_cnt++; if (bus_cycles !== base_bus || tx_hs !== base_tx)
      $display("FAIL idle_silent: bus %0d tx %0d required %0d/%0d", bus_cycles, tx_hs, base_bus, base_tx);
    else pass_cnt++;
    ack_delay = 2;
    exp_q.push_back(8'h06);
    send_write(32'h0000_0020, 32'h1122_3344);
    drain("idle_next", 1, 1'b0);
    chk_cnt++; if (last_addr !== 32'h0000_0020 || last_dat !== 32'h1122_3344 || last_we !== 1'b1)
      $display("FAIL idle_next_bus: got %h/%h/%b required 00000020/11223344/1", last_addr, last_dat, last_we);
    else pass_cnt++;
  endtask

  task automatic test_bus_timeout();
    ack_en = 1'b0;
    exp_q.push_back(8'h15);
    send_read(32'h0000_0008);
    drain("bus_to", 1, 1'b0);
    chk_cnt++; if (stb_len !== BUS_TO) $display("FAIL bus_to_len: stb cycles %0d required %0d", stb_len, BUS_TO); else pass_cnt++;
    // ACK on the final permitted cycle must beat the timeout.
    ack_en = 1'b1; ack_delay = BUS_TO - 1; rd_data = 32'hCAFE_F00D;
    exp_q.push_back(8'h0D); exp_q.push_back(8'hF0); exp_q.push_back(8'hFE); exp_q.push_back(8'hCA);
    send_read(32'h0000_000C);
    drain("ack_vs_to", 4, 1'b0);
    chk_cnt++; if (stb_len !== BUS_TO) $display("FAIL ack_vs_to_len: stb cycles %0d required %0d", stb_len, BUS_TO); else pass_cnt++;
  endtask

  task automatic test_overrun_and_reset();
    int base_tx;
    ack_en = 1'b1; ack_delay = 5; rd_data = 32'hA5A5_5A5A;
    exp_q.push_back(8'h5A); exp_q.push_back(8'h5A); exp_q.push_back(8'hA5); exp_q.push_back(8'hA5);
    send_read(32'h0000_0010);
    send_byte(8'h41);
    chk_cnt++; if (bif.o_OVERRUN !== 1'b1) $display("FAIL overrun_set: got %b required 1", bif.o_OVERRUN); else pass_cnt++;
    drain("overrun", 4, 1'b0);
    base_tx = tx_hs;
    repeat (20) @(negedge clk);
    chk_cnt++; if (tx_hs !== base_tx || bif.o_OVERRUN !== 1'b1)
      $display("FAIL overrun_ignored: extra tx %0d overrun %b required 0/1", tx_hs - base_tx, bif.o_OVERRUN);
    else pass_cnt++;
    bif.i_TX_READY = 1'b0;
    send_byte(8'h41);
    chk_cnt++; if (bif.o_TX_VALID !== 1'b1 || bif.o_TX_DATA !== 8'h15)
      $display("FAIL resp_hold: valid %b data %02h required 1/15", bif.o_TX_VALID, bif.o_TX_DATA);
    else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    chk_cnt++; if (bif.o_TX_VALID !== 1'b0 || bif.o_OVERRUN !== 1'b0 || bif.o_STB !== 1'b0)
      $display("FAIL reset_mid_resp: valid %b overrun %b stb %b required 0/0/0", bif.o_TX_VALID, bif.o_OVERRUN, bif.o_STB);
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bif.i_RX_DATA  = 8'h0;
    bif.i_RX_VALID = 1'b0;
    bif.i_TX_READY = 1'b0;
    @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_bad_opcode();
    test_idle_timeout();
    test_bus_timeout();
    test_overrun_and_reset();
    chk_cnt++; if (exp_q.size() !== 0) $display("FAIL scoreboard_empty: %0d bytes left required 0", exp_q.size()); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/uart_wb_bridge.md
Name: uart_wb_bridge

Overview:
- Wishbone classic bus initiator driven by a byte-stream command protocol from the UART byte engines. It lets a host PC read and write any memory-mapped location over the serial link, for debug and program loading.
- Sits between a UART RX/TX byte engine (byte-stream side) and the shared bus, in parallel with the CPU master.
- Decodes 'W'/'R' command frames, performs one 32-bit bus cycle per frame, and returns an ACK byte or read data bytes.

Parameters:
- ADDR_WIDTH, 32, bus address width; frame always carries 4 address bytes, upper bits beyond ADDR_WIDTH ignored.
- DATA_WIDTH, 32, bus data width; fixed at 32 for this protocol.
- BUS_TIMEOUT, 1024, max cycles o_STB is held waiting for i_ACK.
- IDLE_TIMEOUT, 1250000, max cycles between bytes of one frame before the partial frame is discarded.

Ports:
- i_CLK  in  1  clock
- i_RST  in  1  reset, synchronous, active-high
- i_RX_DATA  in  8  received byte
- i_RX_VALID  in  1  one-cycle strobe, byte valid; no backpressure
- o_TX_DATA  out  8  byte to transmit
- o_TX_VALID  out  1  byte pending
- i_TX_READY  in  1  TX engine accepts byte when high with o_TX_VALID
- o_ADDR  out  ADDR_WIDTH  bus address
- o_DATA  out  DATA_WIDTH  bus write data
- i_DATA  in  DATA_WIDTH  bus read data
- o_WE  out  1  bus write enable
- o_SEL  out  4  byte selects, constant 4'b1111
- o_STB  out  1  bus strobe
- o_CYC  out  1  bus cycle
- i_ACK  in  1  bus acknowledge
- o_OVERRUN  out  1  sticky: RX byte arrived while not accepting

Behaviour:
- Reset values: all outputs 0 except o_SEL = 4'b1111. Reset clears FSM, counters, shift buffers and o_OVERRUN, and aborts any bus cycle. o_CYC and o_STB drop on the cycle after i_RST is sampled high.
- Frame format:
  - Byte 0 is the opcode: 0x57 'W' or 0x52 'R'.
  - Next 4 bytes are the address, little-endian.
  - 'W' is followed by 4 data bytes, little-endian.
- Responses:
  - 'W' success: single byte 0x06.
  - 'R' success: 4 data bytes, little-endian.
  - Error: single byte 0x15.
- FSM states: IDLE, ADDR, WDATA, BUS, RESP.
- IDLE:
  - On i_RX_VALID with 'W' or 'R', latch opcode and go to ADDR with byte count 0.
  - Any other byte: queue 0x15 and go to RESP.
- ADDR: shift each byte into bits [8k+7:8k]. After the 4th byte go to WDATA ('W') or BUS ('R').
- WDATA: same shifting into the write-data register. After the 4th byte go to BUS.
- Inter-byte timeout (ADDR and WDATA only): an idle counter resets on each accepted byte. When it reaches IDLE_TIMEOUT, return to IDLE silently with no response.
- BUS:
  - o_CYC=o_STB=1 starting the cycle after the last frame byte is accepted.
  - o_WE=1 for 'W'; o_ADDR and o_DATA are stable for the whole cycle.
  - Hold until i_ACK is sampled high. That cycle, capture i_DATA (reads), then drop o_CYC, o_STB and o_WE on the next cycle. At most one ACK is consumed per frame.
  - If i_ACK is not seen within BUS_TIMEOUT cycles of o_STB rising, drop o_CYC/o_STB and respond 0x15.
- RESP:
  - o_TX_VALID=1 with o_TX_DATA stable until i_TX_READY; the byte counter advances on each handshake.
  - After the last byte, return to IDLE on the next cycle.
  - Back-to-back bytes are allowed: the next byte is presented the cycle after a handshake.
- Overrun:
  - i_RX_VALID in BUS or RESP: the byte is dropped and o_OVERRUN is set.
  - o_OVERRUN clears only on reset.
- Simultaneous events:
  - i_RX_VALID on the same cycle the idle timeout fires: the timeout wins and the byte is dropped, with no overrun flag.
  - i_ACK on the same cycle the bus timeout fires: the ACK wins and a normal response is sent.
- Throughput: one command in flight; latency from last RX byte to o_STB is 1 cycle.

Test Plan:
- RX 57 10 00 00 80 EF BE AD DE -> one bus write at o_ADDR=0x80000010 with o_DATA=0xDEADBEEF, o_WE=1, o_SEL=F; ACK after 3 cycles -> TX 06.
- RX 52 04 00 00 80, slave ACKs with i_DATA=0x12345678 -> o_WE=0 during cycle, TX 78 56 34 12 in order; i_TX_READY toggling every other cycle keeps o_TX_DATA stable.
- RX 41 -> no bus cycle, TX 15, back to IDLE; the following 'R' frame then works normally.
- RX 57 01 02, then silence for IDLE_TIMEOUT cycles (set to 100) -> no TX byte, no bus cycle; the next complete frame executes.
- 'R' frame with i_ACK held low, BUS_TIMEOUT=16 -> o_STB high exactly 16 cycles then low, TX 15.
- Extra RX byte during BUS -> o_OVERRUN=1 and the byte is ignored; assert i_RST mid-RESP -> o_TX_VALID=0, o_OVERRUN=0 next cycle.
